frm_buffer: RTL and testbench

FRM_BUFFER -- requirements
Module: frm_buffer

---
 rtl/frm_buffer.sv | 203 ++++++++++++++++++++
 tb/tb_frm_buffer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/frm_buffer.sv
// Double-banked frame buffer between the Nyquist decimator and a frame consumer.
// One bank fills while the other is held for random-access reads.
module frm_buffer #(
   parameter int ADDR_WIDTH = 9,
   parameter int MEM_WIDTH  = 32,
   parameter int IN_WIDTH   = 24,
   parameter int DEPTH_LOG2 = 6
) (
   input  logic                       Clk_CI,
   input  logic                       Rst_RBI,
   input  logic                       WrEn_SI,
   input  logic [ADDR_WIDTH-1:0]      Addr_DI,
   input  logic [MEM_WIDTH-1:0]       PAR_In_DI,
   input  logic signed [IN_WIDTH-1:0] FRM_In_DI,
   input  logic                       FRM_Valid_SI,
   input  logic [DEPTH_LOG2-1:0]      FRM_RdAddr_DI,
   input  logic                       FRM_Done_SI,
   output logic signed [IN_WIDTH-1:0] FRM_Out_DO,
   output logic                       FRM_FrameRdy_DO,
   output logic                       FRM_Bank_DO,
   output logic                       FRM_Overrun_DO
);

   localparam int NWORDS = 2 ** ADDR_WIDTH;
   localparam int DEPTH  = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FULL_LEN = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0]   LEN_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2-1:0] IDX_ZERO = {DEPTH_LOG2{1'b0}};
   localparam logic [DEPTH_LOG2-1:0] IDX_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] OVR_ADDR = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      FILL      = 2'd0,
      FILL_HOLD = 2'd1,
      FULL_HOLD = 2'd2
   } state_t;

   state_t                     state_r, state_n;
   logic [MEM_WIDTH-1:0]       par_mem_r [NWORDS];
   logic signed [IN_WIDTH-1:0] bank_mem_r [2*DEPTH];
   logic                       wr_bank_r, wr_bank_n;
   logic                       rd_bank_r, rd_bank_n;
   logic                       rdy_r, rdy_n;
   logic                       ovr_r, ovr_n;
   logic [DEPTH_LOG2-1:0]      idx_r, idx_n;
   logic [DEPTH_LOG2:0]        len_r, len_n;
   logic [DEPTH_LOG2:0]        w0_len_s, fresh_len_s, cur_len_s;
   logic                       we_s, drop_s, last_s;

   // Frame length: fresh from word 0 at index 0, latched value for the rest of the frame.
   always_comb begin
      w0_len_s = par_mem_r[0][DEPTH_LOG2:0];
      if ((w0_len_s == {(DEPTH_LOG2+1){1'b0}}) || (w0_len_s > FULL_LEN)) begin
         fresh_len_s = FULL_LEN;
      end else begin
         fresh_len_s = w0_len_s;
      end
      if (idx_r == IDX_ZERO) begin
         cur_len_s = fresh_len_s;
      end else begin
         cur_len_s = len_r;
      end
      last_s = ({1'b0, idx_r} == (cur_len_s - LEN_ONE));
   end

   // Next-state and next-value logic of the bank-control FSM.
   always_comb begin
      state_n   = state_r;
      wr_bank_n = wr_bank_r;
      rd_bank_n = rd_bank_r;
      idx_n     = idx_r;
      rdy_n     = rdy_r;
      we_s      = 1'b0;
      drop_s    = 1'b0;
      case (state_r)
         FILL: begin
            if (FRM_Valid_SI) begin
               we_s = 1'b1;
               if (last_s) begin
                  state_n   = FILL_HOLD;
                  rd_bank_n = wr_bank_r;
                  wr_bank_n = ~wr_bank_r;
                  idx_n     = IDX_ZERO;
                  rdy_n     = 1'b1;
               end else begin
                  idx_n = idx_r + IDX_ONE;
               end
            end else begin
               idx_n = idx_r;
            end
         end
         FILL_HOLD: begin
            if (FRM_Valid_SI) begin
               we_s = 1'b1;
               if (last_s) begin
                  idx_n = IDX_ZERO;
                  // Completion and release together: hand the new frame straight over.
                  if (FRM_Done_SI) begin
                     rd_bank_n = wr_bank_r;
                     wr_bank_n = ~wr_bank_r;
                  end else begin
                     state_n = FULL_HOLD;
                  end
               end else begin
                  idx_n = idx_r + IDX_ONE;
                  if (FRM_Done_SI) begin
                     state_n = FILL;
                     rdy_n   = 1'b0;
                  end else begin
                     state_n = FILL_HOLD;
                  end
               end
            end else if (FRM_Done_SI) begin
               state_n = FILL;
               rdy_n   = 1'b0;
            end else begin
               state_n = FILL_HOLD;
            end
         end
         FULL_HOLD: begin
            drop_s = FRM_Valid_SI;
            if (FRM_Done_SI) begin
               state_n   = FILL_HOLD;
               rd_bank_n = wr_bank_r;
               wr_bank_n = ~wr_bank_r;
               idx_n     = IDX_ZERO;
            end else begin
               state_n = FULL_HOLD;
            end
         end
         default: begin
            state_n = FILL;
            rdy_n   = 1'b0;
         end
      endcase
      if (we_s && (idx_r == IDX_ZERO)) begin
         len_n = fresh_len_s;
      end else begin
         len_n = len_r;
      end
      // A dropped sample outranks a clearing write in the same cycle.
      if (drop_s) begin
         ovr_n = 1'b1;
      end else if (WrEn_SI && (Addr_DI == OVR_ADDR)) begin
         ovr_n = 1'b0;
      end else begin
         ovr_n = ovr_r;
      end
   end

   // Control state registers.
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         state_r   <= FILL;
         wr_bank_r <= 1'b0;
         rd_bank_r <= 1'b0;
         idx_r     <= IDX_ZERO;
         len_r     <= FULL_LEN;
         rdy_r     <= 1'b0;
         ovr_r     <= 1'b0;
      end else begin
         state_r   <= state_n;
         wr_bank_r <= wr_bank_n;
         rd_bank_r <= rd_bank_n;
         idx_r     <= idx_n;
         len_r     <= len_n;
         rdy_r     <= rdy_n;
         ovr_r     <= ovr_n;
      end
   end

   // Parameter memory.
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         for (int i = 0; i < NWORDS; i++) begin
            par_mem_r[i] <= {MEM_WIDTH{1'b0}};
         end
      end else if (WrEn_SI) begin
         par_mem_r[Addr_DI] <= PAR_In_DI;
      end
   end

   // Sample banks, deliberately left unreset.
   always_ff @(posedge Clk_CI) begin
      if (we_s) begin
         bank_mem_r[{wr_bank_r, idx_r}] <= FRM_In_DI;
      end
   end

   // Registered read port into the held bank.
   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
         FRM_Out_DO <= {IN_WIDTH{1'b0}};
      end else begin
         FRM_Out_DO <= bank_mem_r[{rd_bank_r, FRM_RdAddr_DI}];
      end
   end

   assign FRM_FrameRdy_DO = rdy_r;
   assign FRM_Bank_DO     = rd_bank_r;
   assign FRM_Overrun_DO  = ovr_r;

endmodule

// File: tb/tb_frm_buffer.sv
// Directed self-checking bench for frm_buffer with hand-computed expectations.
module tb_frm_buffer;

   logic                Clk_CI = 1'b0;
   logic                Rst_RBI;
   logic                WrEn_SI;
   logic [8:0]          Addr_DI;
   logic [31:0]         PAR_In_DI;
   logic signed [23:0]  FRM_In_DI;
   logic                FRM_Valid_SI;
   logic [5:0]          FRM_RdAddr_DI;
   logic                FRM_Done_SI;
   logic signed [23:0]  FRM_Out_DO;
   logic                FRM_FrameRdy_DO;
   logic                FRM_Bank_DO;
   logic                FRM_Overrun_DO;

   int n_cmp = 0;
   int n_err = 0;

   frm_buffer dut (
      .Clk_CI          (Clk_CI),
      .Rst_RBI         (Rst_RBI),
      .WrEn_SI         (WrEn_SI),
      .Addr_DI         (Addr_DI),
      .PAR_In_DI       (PAR_In_DI),
      .FRM_In_DI       (FRM_In_DI),
      .FRM_Valid_SI    (FRM_Valid_SI),
      .FRM_RdAddr_DI   (FRM_RdAddr_DI),
      .FRM_Done_SI     (FRM_Done_SI),
      .FRM_Out_DO      (FRM_Out_DO),
      .FRM_FrameRdy_DO (FRM_FrameRdy_DO),
      .FRM_Bank_DO     (FRM_Bank_DO),
      .FRM_Overrun_DO  (FRM_Overrun_DO)
   );

   always #5 Clk_CI = ~Clk_CI;

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk_CI);
      #1;
   endtask

   task automatic idle();
      WrEn_SI = 1'b0; Addr_DI = 9'd0; PAR_In_DI = 32'd0;
      FRM_In_DI = 24'sd0; FRM_Valid_SI = 1'b0; FRM_RdAddr_DI = 6'd0; FRM_Done_SI = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      Rst_RBI = 1'b0;
      tick();
      Rst_RBI = 1'b1;
      tick();
   endtask

   task automatic par_wr(input logic [8:0] a, input logic [31:0] d);
      WrEn_SI = 1'b1; Addr_DI = a; PAR_In_DI = d;
      tick();
      WrEn_SI = 1'b0;
   endtask

   task automatic push(input int v, input logic done);
      FRM_Valid_SI = 1'b1; FRM_In_DI = 24'(v); FRM_Done_SI = done;
      tick();
      FRM_Valid_SI = 1'b0; FRM_Done_SI = 1'b0;
   endtask

   task automatic done_pulse();
      FRM_Done_SI = 1'b1;
      tick();
      FRM_Done_SI = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [5:0] a, input int exp);
      FRM_RdAddr_DI = a;
      tick();
      chk(tag, FRM_Out_DO, exp);
   endtask

   initial begin
      idle();
      Rst_RBI = 1'b0;
      #12;
      chk("rst_rdy", FRM_FrameRdy_DO, 0);
      chk("rst_bank", FRM_Bank_DO, 0);
      chk("rst_ovr", FRM_Overrun_DO, 0);
      chk("rst_out", FRM_Out_DO, 0);
      Rst_RBI = 1'b1;
      tick();

      // Basic 4-sample frame
      par_wr(9'd0, 32'd4);
      push(10, 1'b0); push(20, 1'b0); push(30, 1'b0);
      chk("rdy_before_last", FRM_FrameRdy_DO, 0);
      push(40, 1'b0);
      chk("rdy_after_4", FRM_FrameRdy_DO, 1);
      chk("bank_f0", FRM_Bank_DO, 0);
      rd("f0_a0", 6'd0, 10); rd("f0_a1", 6'd1, 20);
      rd("f0_a2", 6'd2, 30); rd("f0_a3", 6'd3, 40);

      // Fill second bank, stall, overrun, release
      push(50, 1'b0); push(60, 1'b0); push(70, 1'b0); push(80, 1'b0);
      chk("full_rdy", FRM_FrameRdy_DO, 1);
      chk("full_bank", FRM_Bank_DO, 0);
      chk("full_ovr0", FRM_Overrun_DO, 0);
      rd("full_keep_a0", 6'd0, 10);
      push(90, 1'b0);
      chk("ovr_set", FRM_Overrun_DO, 1);
      done_pulse();
      chk("rel_bank", FRM_Bank_DO, 1);
      chk("rel_rdy", FRM_FrameRdy_DO, 1);
      rd("f1_a0", 6'd0, 50); rd("f1_a1", 6'd1, 60);
      rd("f1_a2", 6'd2, 70); rd("f1_a3", 6'd3, 80);
      par_wr(9'd1, 32'd0);
      chk("ovr_clr", FRM_Overrun_DO, 0);

      // Completion and Done in the same cycle
      push(100, 1'b0); push(110, 1'b0); push(120, 1'b0);
      push(130, 1'b1);
      chk("swap_rdy", FRM_FrameRdy_DO, 1);
      chk("swap_bank", FRM_Bank_DO, 0);
      rd("f2_a0", 6'd0, 100); rd("f2_a3", 6'd3, 130);

      // Clearing write coincides with a dropped sample
      push(1, 1'b0); push(2, 1'b0); push(3, 1'b0); push(4, 1'b0);
      WrEn_SI = 1'b1; Addr_DI = 9'd1; PAR_In_DI = 32'd0;
      push(5, 1'b0);
      WrEn_SI = 1'b0;
      chk("ovr_set_wins", FRM_Overrun_DO, 1);
      par_wr(9'd1, 32'd0);
      chk("ovr_clr2", FRM_Overrun_DO, 0);
      done_pulse();
      chk("f3_bank", FRM_Bank_DO, 1);
      rd("f3_a0", 6'd0, 1); rd("f3_a3", 6'd3, 4);

      // Done alone releases; Done in FILL is ignored
      done_pulse();
      chk("release_rdy", FRM_FrameRdy_DO, 0);
      done_pulse();
      chk("fill_done_rdy", FRM_FrameRdy_DO, 0);
      chk("fill_done_bank", FRM_Bank_DO, 1);

      // Word 0 = 0 gives a 64-sample frame
      do_reset();
      for (int i = 0; i < 63; i++) push(1000 + i, 1'b0);
      chk("len0_rdy63", FRM_FrameRdy_DO, 0);
      push(1063, 1'b0);
      chk("len0_rdy64", FRM_FrameRdy_DO, 1);
      chk("len0_bank", FRM_Bank_DO, 0);
      rd("len0_a63", 6'd63, 1063);

      // Word 0 = 100 saturates to 64
      do_reset();
      par_wr(9'd0, 32'd100);
      for (int i = 0; i < 63; i++) push(2000 + i, 1'b0);
      chk("len100_rdy63", FRM_FrameRdy_DO, 0);
      push(2063, 1'b0);
      chk("len100_rdy64", FRM_FrameRdy_DO, 1);
      rd("len100_a0", 6'd0, 2000);

      // Reset mid-frame discards the partial frame
      do_reset();
      par_wr(9'd0, 32'd4);
      push(11, 1'b0); push(12, 1'b0);
      Rst_RBI = 1'b0;
      #2;
      chk("midrst_rdy", FRM_FrameRdy_DO, 0);
      chk("midrst_out", FRM_Out_DO, 0);
      tick();
      Rst_RBI = 1'b1;
      tick();
      par_wr(9'd0, 32'd4);
      push(-5, 1'b0); push(7, 1'b0); push(8, 1'b0);
      chk("midrst_rdy3", FRM_FrameRdy_DO, 0);
      push(9, 1'b0);
      chk("midrst_rdy4", FRM_FrameRdy_DO, 1);
      chk("midrst_bank", FRM_Bank_DO, 0);
      rd("midrst_a0", 6'd0, -5); rd("midrst_a3", 6'd3, 9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
